// File: rtl/atp_pay_ctrl.sv
// atp_pay_ctrl: bill-payment terminal controller.
// Tracks the outstanding amount of one bill across partial payments: account
// balance first (optional), then card/UPI, cash or DD/cheque. Adds an
// inactivity timeout, a bounded retry count, cash change and a valid/ready
// receipt printer handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   qr_valid, qr_amount      scanned bill total
//   user_confirm/_cancel     user accepts the bill / aborts the transaction
//   use_balance, balance     pay from balance first; balance sampled in BAL
//   mode_valid, mode_sel     0 card/UPI, 1 cash, 2 DD/cheque, 3 reserved
//   pay_done, pay_ok,        peripheral result; paid_amount is only used
//   paid_amount              for cash
//   prn_ready                printer accepts the receipt
//   state_out                current state encoding
//   due                      outstanding amount
//   deduct_valid/_amt        one-cycle balance debit request
//   change_amt               cash change, valid in SUCCESS/PRINT
//   prn_valid, prn_amount    receipt request and bill total
//   retry_cnt                FAIL entries in this transaction
//   abort                    one-cycle pulse on cancel, timeout or retry exhaustion
module atp_pay_ctrl #(
  parameter int AMT_W     = 16,
  parameter int TIMEOUT   = 1000,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qr_valid,
  input  logic [AMT_W-1:0] qr_amount,
  input  logic             user_confirm,
  input  logic             user_cancel,
  input  logic             use_balance,
  input  logic [AMT_W-1:0] balance,
  input  logic             mode_valid,
  input  logic [1:0]       mode_sel,
  input  logic             pay_done,
  input  logic             pay_ok,
  input  logic [AMT_W-1:0] paid_amount,
  input  logic             prn_ready,
  output logic [3:0]       state_out,
  output logic [AMT_W-1:0] due,
  output logic             deduct_valid,
  output logic [AMT_W-1:0] deduct_amt,
  output logic [AMT_W-1:0] change_amt,
  output logic             prn_valid,
  output logic [AMT_W-1:0] prn_amount,
  output logic [3:0]       retry_cnt,
  output logic             abort
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SHOW     = 4'd1,
    S_CHOOSE   = 4'd2,
    S_BAL      = 4'd3,
    S_OTHER    = 4'd4,
    S_WAIT_PAY = 4'd5,
    S_FAIL     = 4'd9,
    S_SUCCESS  = 4'd10,
    S_PRINT    = 4'd11
  } state_t;

  localparam int               TMO_W       = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [1:0]       MODE_CASH   = 2'd1;
  localparam logic [1:0]       MODE_RSVD   = 2'd3;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       mode;
  logic             tmo_hit;
  logic [3:0]       retry_next;

  assign state_out  = state;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign retry_next = retry_cnt + 4'd1;

  // Transaction FSM with all outputs registered. The idle counter defaults to
  // zero every cycle and only advances while a waiting state is held, so any
  // state change clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      tmo_cnt      <= '0;
      mode         <= 2'd0;
      due          <= '0;
      deduct_valid <= 1'b0;
      deduct_amt   <= '0;
      change_amt   <= '0;
      prn_valid    <= 1'b0;
      prn_amount   <= '0;
      retry_cnt    <= 4'd0;
      abort        <= 1'b0;
    end else begin
      deduct_valid <= 1'b0;
      abort        <= 1'b0;
      tmo_cnt      <= '0;
      case (state)
        S_IDLE: begin
          if (qr_valid && (qr_amount != '0)) begin
            state      <= S_SHOW;
            due        <= qr_amount;
            prn_amount <= qr_amount;
            retry_cnt  <= 4'd0;
            change_amt <= '0;
          end
        end
        // Nothing has been paid yet, so a timeout here aborts instead of failing.
        S_SHOW: begin
          if (user_cancel) begin
            state <= S_IDLE;
            abort <= 1'b1;
          end else if (user_confirm) begin
            state <= S_CHOOSE;
          end else if (tmo_hit) begin
            state <= S_IDLE;
            abort <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_CHOOSE: begin
          if (user_cancel) begin
            state <= S_IDLE;
            abort <= 1'b1;
          end else if (use_balance) begin
            state <= S_BAL;
          end else begin
            state <= S_OTHER;
          end
        end
        // Debit whatever the balance can cover; a zero balance skips the pulse.
        S_BAL: begin
          if (balance >= due) begin
            deduct_amt   <= due;
            deduct_valid <= (due != '0);
            due          <= '0;
            state        <= S_SUCCESS;
          end else if (balance == '0) begin
            deduct_amt <= '0;
            state      <= S_OTHER;
          end else begin
            deduct_amt   <= balance;
            deduct_valid <= 1'b1;
            due          <= due - balance;
            state        <= S_OTHER;
          end
        end
        S_OTHER: begin
          if (user_cancel) begin
            state <= S_IDLE;
            abort <= 1'b1;
          end else if (mode_valid && (mode_sel != MODE_RSVD)) begin
            mode  <= mode_sel;
            state <= S_WAIT_PAY;
          end else if (tmo_hit) begin
            state <= S_FAIL;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        // Card and DD settle the full due; cash may be partial or give change.
        S_WAIT_PAY: begin
          if (user_cancel) begin
            state <= S_IDLE;
            abort <= 1'b1;
          end else if (pay_done) begin
            if (!pay_ok) begin
              state <= S_FAIL;
            end else if (mode != MODE_CASH) begin
              due   <= '0;
              state <= S_SUCCESS;
            end else if (paid_amount >= due) begin
              change_amt <= paid_amount - due;
              due        <= '0;
              state      <= S_SUCCESS;
            end else begin
              due   <= due - paid_amount;
              state <= S_OTHER;
            end
          end else if (tmo_hit) begin
            state <= S_FAIL;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_FAIL: begin
          retry_cnt <= retry_next;
          if (retry_next == RETRY_LIMIT) begin
            abort <= 1'b1;
            state <= S_IDLE;
          end else begin
            state <= S_OTHER;
          end
        end
        S_SUCCESS: begin
          prn_valid <= 1'b1;
          state     <= S_PRINT;
        end
        // prn_valid is always high here, so prn_ready alone completes the handshake.
        S_PRINT: begin
          if (prn_ready) begin
            prn_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          prn_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
